// File: rtl/shot_clock_ctrl_if.sv
// Control and display bundle between the game logic, the shot-clock
// controller and the seven-segment multiplexer.
interface shot_clock_ctrl_if;
  logic       start;
  logic       pause;
  logic       reload;
  logic       scan_en;
  logic [3:0] d3;
  logic [3:0] d2;
  logic [3:0] d1;
  logic [3:0] d0;
  logic       running;
  logic       expired;
  logic       buzz;

  modport master (
    output start, pause, reload,
    input  scan_en, d3, d2, d1, d0, running, expired, buzz
  );

  modport slave (
    input  start, pause, reload,
    output scan_en, d3, d2, d1, d0, running, expired, buzz
  );
endinterface

// File: rtl/shot_clock_ctrl.sv
// Shot-clock countdown: packed-BCD value decremented once per tick under
// start/pause/reload control, with digit-scan strobe, blink on expiry and
// a one-cycle buzzer pulse when the count reaches 00.
module shot_clock_ctrl #(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned SCAN_DIV   = 100_000,
  parameter logic [3:0]  START_TENS = 4'd1,
  parameter logic [3:0]  START_ONES = 4'd0
) (
  input  logic            clk,
  input  logic            rst,
  shot_clock_ctrl_if.slave bus
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    BLANK     = 4'hF;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          blink_q, blink_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          scan_en_q, scan_en_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;
  logic          buzz_q, buzz_d;
  logic [3:0]    d1_q, d1_d;
  logic [3:0]    d0_q, d0_d;

  // Next-state, countdown and registered-output computation.
  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    tcnt_d    = tcnt_q;
    blink_d   = blink_q;
    buzz_d    = 1'b0;
    scan_en_d = (scnt_q == SCAN_LAST);
    scnt_d    = (scnt_q == SCAN_LAST) ? '0 : scnt_q + 1'b1;

    if (bus.reload) begin
      state_d = IDLE;
      tens_d  = START_TENS;
      ones_d  = START_ONES;
      tcnt_d  = '0;
      blink_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            tcnt_d = '0;
            if ({tens_q, ones_q} != 8'h00) begin
              state_d = RUN;
            end else begin
              state_d = EXPIRED;
              buzz_d  = 1'b1;
              blink_d = 1'b0;
            end
          end
        end
        RUN: begin
          // A pause on a tick edge holds tcnt at its last value, so the
          // deferred tick fires on the first advancing edge after resume.
          if (bus.pause) begin
            state_d = PAUSED;
          end else if (tcnt_q == TICK_LAST) begin
            tcnt_d = '0;
            if (ones_q == 4'd0) begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end else begin
              ones_d = ones_q - 4'd1;
            end
            if (tens_q == 4'd0 && ones_q == 4'd1) begin
              state_d = EXPIRED;
              buzz_d  = 1'b1;
              blink_d = 1'b0;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        PAUSED: begin
          if (bus.start) state_d = RUN;
        end
        EXPIRED: begin
          if (tcnt_q == TICK_LAST) begin
            tcnt_d  = '0;
            blink_d = ~blink_q;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);
    expired_d = (state_d == EXPIRED);
    d1_d      = (state_d == EXPIRED && blink_d) ? BLANK : tens_d;
    d0_d      = (state_d == EXPIRED && blink_d) ? BLANK : ones_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tens_q    <= START_TENS;
      ones_q    <= START_ONES;
      tcnt_q    <= '0;
      blink_q   <= 1'b0;
      scnt_q    <= '0;
      scan_en_q <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      buzz_q    <= 1'b0;
      d1_q      <= START_TENS;
      d0_q      <= START_ONES;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      tcnt_q    <= tcnt_d;
      blink_q   <= blink_d;
      scnt_q    <= scnt_d;
      scan_en_q <= scan_en_d;
      running_q <= running_d;
      expired_q <= expired_d;
      buzz_q    <= buzz_d;
      d1_q      <= d1_d;
      d0_q      <= d0_d;
    end
  end

  assign bus.scan_en = scan_en_q;
  assign bus.running = running_q;
  assign bus.expired = expired_q;
  assign bus.buzz    = buzz_q;
  assign bus.d3      = BLANK;
  assign bus.d2      = BLANK;
  assign bus.d1      = d1_q;
  assign bus.d0      = d0_q;

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Bench for shot_clock_ctrl: directed scenarios plus random pulses, checked
// every cycle against a seconds-level model of the shot clock.
module tb_shot_clock_ctrl;

  localparam int TD = 8;
  localparam int SD = 4;
  localparam int START_VAL = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shot_clock_ctrl_if bus ();
  shot_clock_ctrl_if bus0 ();

  shot_clock_ctrl #(
    .TICK_DIV(TD), .SCAN_DIV(SD), .START_TENS(4'd1), .START_ONES(4'd0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  shot_clock_ctrl #(
    .TICK_DIV(TD), .SCAN_DIV(SD), .START_TENS(4'd0), .START_ONES(4'd0)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: shot clock as whole seconds plus elapsed clocks within a second.
  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_EXPIRED} mode_t;
  mode_t m_mode;
  int    m_val;
  int    m_elapsed;
  bit    m_blink;
  bit    m_buzz;
  int    m_scan_cnt;
  bit    m_scan;

  task automatic model_reset();
    m_mode = M_IDLE; m_val = START_VAL; m_elapsed = 0;
    m_blink = 0; m_buzz = 0; m_scan_cnt = 0; m_scan = 0;
  endtask

  task automatic model_edge(input bit s, input bit p, input bit r);
    m_buzz     = 0;
    m_scan     = (m_scan_cnt == SD - 1);
    m_scan_cnt = (m_scan_cnt + 1) % SD;
    if (r) begin
      m_mode = M_IDLE; m_val = START_VAL; m_elapsed = 0; m_blink = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (s) begin
          m_elapsed = 0;
          if (m_val != 0) m_mode = M_RUN;
          else begin m_mode = M_EXPIRED; m_buzz = 1; m_blink = 0; end
        end
        M_RUN: if (p) m_mode = M_PAUSED;
        else begin
          m_elapsed++;
          if (m_elapsed == TD) begin
            m_elapsed = 0;
            m_val--;
            if (m_val == 0) begin m_mode = M_EXPIRED; m_buzz = 1; m_blink = 0; end
          end
        end
        M_PAUSED: if (s) m_mode = M_RUN;
        M_EXPIRED: begin
          m_elapsed++;
          if (m_elapsed == TD) begin m_elapsed = 0; m_blink = ~m_blink; end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [3:0] e1, e0;
    bit blank;
    blank = (m_mode == M_EXPIRED) && m_blink;
    e1 = blank ? 4'hF : 4'(m_val / 10);
    e0 = blank ? 4'hF : 4'(m_val % 10);
    chk1("scan_en", bus.scan_en, m_scan);
    chk1("running", bus.running, m_mode == M_RUN);
    chk1("expired", bus.expired, m_mode == M_EXPIRED);
    chk1("buzz",    bus.buzz,    m_buzz);
    chk4("d3", bus.d3, 4'hF);
    chk4("d2", bus.d2, 4'hF);
    chk4("d1", bus.d1, e1);
    chk4("d0", bus.d0, e0);
  endtask

  // One clock: drive inputs, advance model on the edge, compare #1 later.
  task automatic step(input bit s, input bit p, input bit r, input bit x);
    bus.start = s; bus.pause = p; bus.reload = r; rst = x;
    @(posedge clk);
    if (x) model_reset();
    else model_edge(s, p, r);
    #1;
    bus.start = 0; bus.pause = 0; bus.reload = 0; rst = 0;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    bus.start = 0; bus.pause = 0; bus.reload = 0;
    bus0.start = 0; bus0.pause = 0; bus0.reload = 0;
    model_reset();

    // Reset held for 5 cycles, then scan-only operation.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    chk4("rst_d1", bus.d1, 4'd1);
    chk4("rst_d0", bus.d0, 4'd0);
    chk1("rst_scan", bus.scan_en, 1'b0);
    idle(12);

    // Full countdown from 10 to expiry, blink, lockout, reload.
    step(1, 0, 0, 0);
    for (int k = 1; k <= 96; k++) begin
      step(0, 0, 0, 0);
      if (k == 7)  chk4("cnt_pre_tick_d0", bus.d0, 4'd0);
      if (k == 8)  chk4("cnt_first_d0", bus.d0, 4'd9);
      if (k == 79) chk4("cnt_01_d0", bus.d0, 4'd1);
      if (k == 80) begin
        chk1("exp_buzz", bus.buzz, 1'b1);
        chk1("exp_level", bus.expired, 1'b1);
        chk1("exp_running", bus.running, 1'b0);
        chk4("exp_d1", bus.d1, 4'd0);
        chk4("exp_d0", bus.d0, 4'd0);
      end
      if (k == 81) chk1("exp_buzz_once", bus.buzz, 1'b0);
      if (k == 88) chk4("blink_off_d1", bus.d1, 4'hF);
      if (k == 96) chk4("blink_on_d1", bus.d1, 4'd0);
    end
    step(1, 0, 0, 0); idle(2);
    step(0, 1, 0, 0); idle(2);
    chk1("lock_expired", bus.expired, 1'b1);
    step(0, 0, 1, 0);
    chk1("reload_expired", bus.expired, 1'b0);
    chk4("reload_d1", bus.d1, 4'd1);
    chk4("reload_d0", bus.d0, 4'd0);
    idle(3);

    // Pause at E0+20 for 50 cycles, resume with tcnt held at 3.
    step(1, 0, 0, 0);
    idle(19);
    step(0, 1, 0, 0);
    chk1("pause_running", bus.running, 1'b0);
    chk4("pause_d0", bus.d0, 4'd8);
    idle(50);
    chk4("pause_hold_d0", bus.d0, 4'd8);
    step(1, 0, 0, 0);
    idle(4);
    chk4("resume_s4_d0", bus.d0, 4'd8);
    step(0, 0, 0, 0);
    chk4("resume_s5_d0", bus.d0, 4'd7);

    // pause+start in RUN pauses; reload+start goes idle at 10.
    idle(3);
    step(1, 1, 0, 0);
    chk1("prio_ps_running", bus.running, 1'b0);
    idle(10);
    step(1, 0, 1, 0);
    chk1("prio_rs_running", bus.running, 1'b0);
    chk4("prio_rs_d1", bus.d1, 4'd1);
    chk4("prio_rs_d0", bus.d0, 4'd0);

    // Pause exactly on a tick edge defers the tick to S+1.
    step(1, 0, 0, 0);
    idle(7);
    step(0, 1, 0, 0);
    chk4("tickpause_d1", bus.d1, 4'd1);
    chk4("tickpause_d0", bus.d0, 4'd0);
    idle(3);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk4("tickpause_s1_d1", bus.d1, 4'd0);
    chk4("tickpause_s1_d0", bus.d0, 4'd9);

    // Reset mid-countdown.
    idle(5);
    step(0, 0, 0, 1);
    chk1("midrst_buzz", bus.buzz, 1'b0);
    chk4("midrst_d0", bus.d0, 4'd0);
    idle(3);

    // Random pulses against the model.
    for (int i = 0; i < 600; i++) begin
      bit s, p, r;
      s = ($urandom_range(0, 5) == 0);
      p = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 79) == 0);
      step(s, p, r, 0);
    end

    // Zero start value goes straight to expiry with a buzz.
    step(0, 0, 0, 1);
    chk4("zero_rst_d0", bus0.d0, 4'd0);
    bus0.start = 1;
    step(0, 0, 0, 0);
    bus0.start = 0;
    chk1("zero_expired", bus0.expired, 1'b1);
    chk1("zero_buzz", bus0.buzz, 1'b1);
    chk1("zero_running", bus0.running, 1'b0);
    chk4("zero_d1", bus0.d1, 4'd0);
    chk4("zero_d0", bus0.d0, 4'd0);
    step(0, 0, 0, 0);
    chk1("zero_buzz_once", bus0.buzz, 1'b0);
    chk1("zero_expired_hold", bus0.expired, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shot_clock_ctrl.md
# shot_clock_ctrl

Countdown controller that sequences the two-digit seven-segment display path. It holds the shot-clock value as packed BCD and decrements it once per second-tick under start/pause/reload control. It drives `d3..d0` and the `scan_en` strobe of `sevenseg_mux`, and flags expiry to the game logic with a level and a one-cycle buzzer pulse.

## Interface
- `TICK_DIV`, 100_000_000: clocks per countdown tick (1 Hz at 100 MHz); must be ≥ 2.
- `SCAN_DIV`, 100_000: clocks per `scan_en` pulse (1 kHz digit scan); must be ≥ 2.
- `START_TENS`, 4'd1: reload tens digit (BCD 0–9).
- `START_ONES`, 4'd0: reload ones digit (BCD 0–9).

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse: begin or resume the countdown.
- `pause`  in  1  one-cycle pulse: freeze the countdown.
- `reload`  in  1  one-cycle pulse: restore the start value and go idle.
- `scan_en`  out  1  one-cycle strobe every `SCAN_DIV` clocks, to `sevenseg_mux`.
- `d3`, `d2`  out  4 each  always 4'hF (blank).
- `d1`, `d0`  out  4 each  tens and ones digits; 4'hF means blank.
- `running`  out  1  high while in RUN.
- `expired`  out  1  high while in EXPIRED.
- `buzz`  out  1  one-cycle pulse on the edge the count reaches 00.

## Operation
- **Scan prescaler:** free-running counter 0..`SCAN_DIV`-1. `scan_en` is high for the single cycle after the counter wraps. It runs in every state and is cleared only by `rst`.
- **Tick prescaler:** `tcnt` counts 0..`TICK_DIV`-1.
  - It advances only on edges where state=RUN and neither `pause` nor `reload` is sampled.
  - A tick fires when `tcnt`=`TICK_DIV`-1 on an advancing edge. On that edge `tcnt` wraps to 0.
  - In EXPIRED, `tcnt` free-runs to time the blink.
- **State machine** (IDLE, RUN, PAUSED, EXPIRED). Input priority: `reload` > `pause` > `start`.
  - **Any state, `reload`:** go to IDLE, value ← START, `tcnt` ← 0, blink ← 0.
  - **IDLE:**
    - `start` with value ≠ 00: go to RUN, `tcnt` ← 0.
    - `start` with value = 00: go to EXPIRED, `buzz` pulses.
  - **RUN:**
    - `pause`: go to PAUSED, `tcnt` held. This applies even on a tick edge, and that tick is not applied.
    - Tick: BCD decrement. If ones=0, then ones←9 and tens←tens−1; else ones←ones−1.
    - A tick that takes the value from 01 to 00 also moves to EXPIRED and pulses `buzz`.
    - `start` is ignored.
  - **PAUSED:**
    - `start`: go to RUN, `tcnt` retained, so the remaining tick time is preserved.
    - `pause` is ignored.
  - **EXPIRED:**
    - Value stays at 00.
    - On entry blink ← 0 and `tcnt` ← 0. Each `tcnt` wrap toggles blink.
    - `start` and `pause` are ignored.
- **Display outputs:**
  - `d1`/`d0` show the value, except in EXPIRED with blink=1, where both are 4'hF.
  - `d3`/`d2` are constant 4'hF.
- **Width rules:** the value is always valid BCD. A decrement below 00 is impossible because the FSM leaves RUN at 00.

## Timing
- All outputs are registered and update on the clock edge.
- **Reset values:** state IDLE, `scan_en`=0, `running`=0, `expired`=0, `buzz`=0, `d3`=`d2`=4'hF, `d1`=`START_TENS`, `d0`=`START_ONES`, both prescalers 0.
- **First scan strobe:** `scan_en` is first high `SCAN_DIV` cycles after `rst` deasserts, then every `SCAN_DIV` cycles.
- **Start from IDLE:** `start` sampled at edge E0.
  - `running`=1 after E0.
  - First decrement is visible after edge E0+`TICK_DIV`, then every `TICK_DIV` edges.
- **Expiry:** on the edge value goes 01→00, `expired`=1, `running`=0, and `buzz`=1 for exactly that one cycle.
- **Resume from PAUSED:** `start` sampled at edge S. The next tick fires at edge S+(`TICK_DIV`−`tcnt`_held).
- **Simultaneous inputs:**
  - `reload` with anything: reload wins.
  - `pause`+`start` in RUN: pause wins.
  - `pause` on a tick edge: no decrement, and the tick fires on the first advancing edge after resume (edge S+1).
- **`rst` mid-operation:** returns to reset values on the next edge. No `buzz` is generated.

## Test plan
Bench parameters: `TICK_DIV`=8, `SCAN_DIV`=4, start value 10.

- **Reset and scan:**
  - Stimulus: hold `rst` 5 cycles, then release.
  - Required: `scan_en` pulses 1 cycle every 4 clocks; `d3..d0` = F,F,1,0; `running`=`expired`=`buzz`=0.
- **Full countdown:**
  - Stimulus: `start` at E0.
  - Required: `d1d0` = 09 after E0+8, then 08…01, and 00 after E0+80.
  - Required: `buzz`=1 only in the cycle following E0+80; `expired`=1 and `running`=0 thereafter.
- **Pause/resume:**
  - Stimulus: `start` at E0, `pause` at E0+20, hold 50 cycles, `start` at S.
  - Required: value 08 through the pause; `running`=0 during the pause.
  - Required: `tcnt` held at 3, so 07 appears after edge S+5.
- **Priority and reload:**
  - Stimulus: in RUN, assert `pause`+`start` together.
  - Required: state is PAUSED.
  - Stimulus: `reload`+`start` together.
  - Required: IDLE, `d1d0`=10, `running`=0.
  - Stimulus: `pause` on a tick edge.
  - Required: no decrement, and the decrement occurs at S+1 after resume.
- **Expired blink and lockout:**
  - Stimulus: reach expiry.
  - Required: `d1d0` alternates 00 / FF every 8 cycles.
  - Stimulus: `start`/`pause` pulses.
  - Required: no change.
  - Stimulus: `reload`.
  - Required: IDLE with 10 and `expired`=0.
- **Zero start value:**
  - Stimulus: `START_TENS`=`START_ONES`=0, `start` at E0.
  - Required: `expired`=1 and `buzz` pulse after E0; display 00.
